// File: rtl/connect4_board_ctrl.sv
// connect4_board_ctrl: owns the Connect-4 board. It accepts column drops,
// places tokens with gravity, runs a four-direction win scan around the last
// token (one direction per cycle), and publishes panel/play/player/winner.
// Every output is a flop, so there is no combinational input-to-output path.
module connect4_board_ctrl #(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int WIN_LEN = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            new_game,
    input  logic                            move_valid,
    input  logic [2:0]                      move_col,
    output logic                            move_ready,
    output logic                            move_err,
    output logic [ROWS-1:0][COLS-1:0][1:0]  panel,
    output logic [COLS-1:0]                 play,
    output logic                            player,
    output logic [1:0]                      winner
);

    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CNT_W = $clog2(ROWS * COLS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLACE,
        S_CHK0,     // horizontal
        S_CHK1,     // vertical
        S_CHK2,     // diagonal up-right
        S_CHK3,     // diagonal up-left
        S_RESOLVE,
        S_OVER
    } state_t;

    state_t                           r_state;
    logic [2:0]                       r_col;
    logic [RW-1:0]                    r_row;
    logic                             r_win;
    logic [CNT_W-1:0]                 r_count;
    logic [ROWS-1:0][COLS-1:0][1:0]   r_panel;
    logic [COLS-1:0]                  r_play;
    logic                             r_player;
    logic [1:0]                       r_winner;
    logic                             r_move_ready;
    logic                             r_move_err;

    logic                             w_col_ok;
    logic                             w_col_full;
    logic [RW-1:0]                    w_drop_row;
    logic [1:0]                       w_code;
    int                               w_dr;
    int                               w_dc;
    int                               w_line_len;

    // Contiguous cells matching `code` stepping (dr,dc) away from (row,col),
    // stopping at the first mismatch or board edge, capped at WIN_LEN-1.
    function automatic int run_len(
        input logic [ROWS-1:0][COLS-1:0][1:0] p,
        input int                             row,
        input int                             col,
        input int                             dr,
        input int                             dc,
        input logic [1:0]                     code
    );
        int   n;
        int   rr;
        int   cc;
        logic go;
        n  = 0;
        go = 1'b1;
        for (int k = 1; k < WIN_LEN; k++) begin
            rr = row + k * dr;
            cc = col + k * dc;
            if (go && rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS &&
                p[rr[RW-1:0]][cc[CW-1:0]] == code) begin
                n++;
            end else begin
                go = 1'b0;
            end
        end
        return n;
    endfunction

    // Token code of the player to move: player0 -> 01, player1 -> 10.
    assign w_code = {r_player, ~r_player};

    // Column legality, landing row and per-state line length around the last token.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        w_col_ok   = (int'(move_col) < COLS);
        w_col_full = 1'b0;
        w_drop_row = '0;
        w_dr       = 0;
        w_dc       = 1;
        for (int c = 0; c < COLS; c++) begin
            if (int'(move_col) == c) begin
                w_col_full = (r_panel[ROWS-1][CW'(c)] != 2'b00);
            end
        end
        // Scanning top-down leaves the lowest empty row as the last hit.
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (r_panel[RW'(r)][r_col] == 2'b00) begin
                w_drop_row = RW'(r);
            end
        end
        case (r_state)
            S_CHK0:  begin w_dr = 0; w_dc = 1;  end
            S_CHK1:  begin w_dr = 1; w_dc = 0;  end
            S_CHK2:  begin w_dr = 1; w_dc = 1;  end
            S_CHK3:  begin w_dr = 1; w_dc = -1; end
            default: begin w_dr = 0; w_dc = 1;  end
        endcase
        w_line_len = 1
                   + run_len(r_panel, int'(r_row), int'(r_col),  w_dr,  w_dc, w_code)
                   + run_len(r_panel, int'(r_row), int'(r_col), -w_dr, -w_dc, w_code);
    end

    // Game FSM: move acceptance, token placement, win scan and result resolution.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (rst || new_game) begin
            // rst and new_game clear to the same state, so their priority is moot.
            r_state      <= S_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_win        <= 1'b0;
            r_count      <= '0;
            r_panel      <= '0;
            r_play       <= '0;
            r_player     <= 1'b0;
            r_winner     <= 2'b00;
            r_move_ready <= 1'b1;
            r_move_err   <= 1'b0;
        end else begin
            r_move_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (move_valid) begin
                        if (!w_col_ok || w_col_full) begin
                            r_move_err <= 1'b1;
                        end else begin
                            r_col        <= move_col;
                            r_row        <= '0;
                            r_win        <= 1'b0;
                            r_move_ready <= 1'b0;
                            r_state      <= S_PLACE;
                        end
                    end
                end
                S_PLACE: begin
                    r_panel[w_drop_row][r_col] <= w_code;
                    r_play                     <= COLS'(1) << r_col;
                    r_row                      <= w_drop_row;
                    r_count                    <= r_count + CNT_W'(1);
                    r_state                    <= S_CHK0;
                end
                S_CHK0, S_CHK1, S_CHK2, S_CHK3: begin
                    if (w_line_len >= WIN_LEN) begin
                        r_win <= 1'b1;
                    end
                    case (r_state)
                        S_CHK0:  r_state <= S_CHK1;
                        S_CHK1:  r_state <= S_CHK2;
                        S_CHK2:  r_state <= S_CHK3;
                        default: r_state <= S_RESOLVE;
                    endcase
                end
                S_RESOLVE: begin
                    if (r_win) begin
                        r_winner <= w_code;
                        r_state  <= S_OVER;
                    end else if (r_count == CNT_W'(ROWS * COLS)) begin
                        r_winner <= 2'b11;
                        r_state  <= S_OVER;
                    end else begin
                        r_player     <= ~r_player;
                        r_move_ready <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                S_OVER: begin
                    r_move_ready <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign move_ready = r_move_ready;
    assign move_err   = r_move_err;
    assign panel      = r_panel;
    assign play       = r_play;
    assign player     = r_player;
    assign winner     = r_winner;

endmodule

// File: tb/tb_connect4_board_ctrl.sv
// tb_connect4_board_ctrl: directed bench for connect4_board_ctrl. A small
// board model tracks expected token placement; winners are hand-derived per script.
module tb_connect4_board_ctrl;

    localparam int ROWS = 6;
    localparam int COLS = 7;

    typedef logic [ROWS-1:0][COLS-1:0][1:0] board_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 new_game;
    logic                 move_valid;
    logic [2:0]           move_col;
    logic                 move_ready;
    logic                 move_err;
    board_t               panel;
    logic [COLS-1:0]      play;
    logic                 player;
    logic [1:0]           winner;

    board_t               m_panel;
    logic                 m_player;
    int                   n_vec = 0;
    int                   n_err = 0;

    int                   seq_draw [7] = '{0, 2, 1, 3, 4, 6, 5};
    int                   seq_ur   [10] = '{2, 1, 3, 2, 4, 3, 4, 3, 4, 4};
    int                   seq_ul   [10] = '{4, 5, 3, 4, 2, 3, 2, 3, 2, 2};
    int                   seq_row  [7] = '{0, 6, 1, 6, 2, 6, 3};

    connect4_board_ctrl #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .new_game   (new_game),
        .move_valid (move_valid),
        .move_col   (move_col),
        .move_ready (move_ready),
        .move_err   (move_err),
        .panel      (panel),
        .play       (play),
        .player     (player),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick();
    endtask

    task automatic start_new_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        m_panel  = '0;
        m_player = 1'b0;
    endtask

    // Full accepted move: checks E0 busy, E1 panel/play, E5 unchanged result, E6 result.
    task automatic do_move(input int col, input logic [1:0] exp_win);
        int              waited;
        int              row;
        logic [COLS-1:0] exp_play;
        waited = 0;
        while (!move_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!move_ready) begin
            check("ready_timeout", 128'(move_ready), 128'(1));
            return;
        end
        move_valid = 1'b1;
        move_col   = 3'(col);
        tick();
        move_valid = 1'b0;
        check("busy_e0", 128'(move_ready), 128'(0));
        row = -1;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (m_panel[3'(r)][3'(col)] == 2'b00) row = r;
        end
        if (row >= 0) m_panel[3'(row)][3'(col)] = {m_player, ~m_player};
        tick();
        check("panel_e1", 128'(panel), 128'(m_panel));
        exp_play = '0;
        exp_play[3'(col)] = 1'b1;
        check("play_e1", 128'(play), 128'(exp_play));
        tick_n(4);
        check("player_e5", 128'(player), 128'(m_player));
        check("winner_e5", 128'(winner), 128'(2'b00));
        tick();
        check("winner_e6", 128'(winner), 128'(exp_win));
        if (exp_win == 2'b00) m_player = ~m_player;
        check("player_e6", 128'(player), 128'(m_player));
        check("ready_e6", 128'(move_ready), 128'(exp_win == 2'b00));
    endtask

    // Illegal request in IDLE: one-cycle error pulse, nothing else changes.
    task automatic try_bad(input int col);
        move_valid = 1'b1;
        move_col   = 3'(col);
        tick();
        move_valid = 1'b0;
        check("err_pulse", 128'(move_err), 128'(1));
        check("err_ready", 128'(move_ready), 128'(1));
        check("err_panel", 128'(panel), 128'(m_panel));
        check("err_player", 128'(player), 128'(m_player));
        tick();
        check("err_clear", 128'(move_err), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        new_game   = 1'b0;
        move_valid = 1'b0;
        move_col   = 3'd0;
        m_panel    = '0;
        m_player   = 1'b0;
        tick_n(2);
        rst = 1'b0;
        check("rst_panel", 128'(panel), 128'(0));
        check("rst_ready", 128'(move_ready), 128'(1));
        check("rst_winner", 128'(winner), 128'(2'b00));
        check("rst_play", 128'(play), 128'(0));

        // Reset in the middle of the win scan (state CHK2).
        move_valid = 1'b1;
        move_col   = 3'd3;
        tick();
        move_valid = 1'b0;
        tick_n(3);
        rst = 1'b1;
        tick_n(2);
        rst = 1'b0;
        check("midrst_panel", 128'(panel), 128'(0));
        check("midrst_winner", 128'(winner), 128'(2'b00));
        check("midrst_player", 128'(player), 128'(0));
        check("midrst_ready", 128'(move_ready), 128'(1));
        check("midrst_err", 128'(move_err), 128'(0));

        // Single drop into column 3 from reset.
        do_move(3, 2'b00);

        // Fill column 0, then a seventh drop must be rejected.
        start_new_game();
        for (int i = 0; i < ROWS; i++) do_move(0, 2'b00);
        try_bad(0);

        // Out-of-range column, and requests while busy are ignored.
        start_new_game();
        try_bad(7);
        move_valid = 1'b1;
        move_col   = 3'd2;
        tick();
        m_panel[0][2] = 2'b01;
        move_col = 3'd4;
        tick_n(6);
        move_valid = 1'b0;
        m_player   = 1'b1;
        check("busy_err", 128'(move_err), 128'(0));
        check("busy_panel", 128'(panel), 128'(m_panel));
        check("busy_player", 128'(player), 128'(1));
        tick();
        check("busy_panel_after", 128'(panel), 128'(m_panel));

        // Horizontal win for player0 on row 0, then OVER ignores input.
        start_new_game();
        for (int i = 0; i < 7; i++) do_move(seq_row[i], (i == 6) ? 2'b01 : 2'b00);
        move_valid = 1'b1;
        move_col   = 3'd4;
        tick_n(3);
        move_valid = 1'b0;
        check("over_err", 128'(move_err), 128'(0));
        check("over_panel", 128'(panel), 128'(m_panel));
        check("over_ready", 128'(move_ready), 128'(0));
        check("over_winner", 128'(winner), 128'(2'b01));
        start_new_game();
        check("ng_panel", 128'(panel), 128'(0));
        check("ng_play", 128'(play), 128'(0));
        check("ng_winner", 128'(winner), 128'(2'b00));
        check("ng_player", 128'(player), 128'(0));
        check("ng_ready", 128'(move_ready), 128'(1));

        // Player1 diagonal wins, both slopes.
        for (int i = 0; i < 10; i++) do_move(seq_ur[i], (i == 9) ? 2'b10 : 2'b00);
        start_new_game();
        for (int i = 0; i < 10; i++) do_move(seq_ul[i], (i == 9) ? 2'b10 : 2'b00);

        // 42-move fill with no line of four: draw.
        start_new_game();
        for (int i = 0; i < ROWS * COLS; i++) begin
            do_move(seq_draw[i % 7], (i == ROWS * COLS - 1) ? 2'b11 : 2'b00);
        end
        check("draw_ready", 128'(move_ready), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
